// File: rtl/serial_pattern_sched_pkg.sv
// serial_pattern_sched_pkg
//   Shared definitions for the serial pattern scheduler:
//   - state_t   : handshake/serialiser FSM states (IDLE, SHIFT, DONE)
//   - len_width : width of the pattern-length field for a given PAT_MAX
package serial_pattern_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Enough bits to hold the values 0..pat_max.
  function automatic int len_width(input int pat_max);
    return (pat_max < 1) ? 1 : $clog2(pat_max + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_sched_pattern_match_core.sv
// pattern_match_core
//   History register, fill counter, pattern compare, overlap handling and
//   saturating match counter for the serial bit stream.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : first bit of a new stream; clears history/fill/count
//   bit_en       : bit_in is emitted this cycle (appears on bit_out next cycle)
//   bit_in       : the bit being emitted
//   pattern      : pattern, bit [len-1] matched first in time
//   len          : pattern length (1..PAT_MAX, already sanitised)
//   overlap      : 1 = overlapping matches, 0 = fill cleared after a match
//   match_pulse  : registered, aligned with the completing bit on bit_out
//   match_count  : registered saturating match count
module pattern_match_core
  import serial_pattern_sched_pkg::*;
#(
  parameter int PAT_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          bit_en,
  input  logic                          bit_in,
  input  logic [PAT_MAX-1:0]            pattern,
  input  logic [len_width(PAT_MAX)-1:0] len,
  input  logic                          overlap,
  output logic                          match_pulse,
  output logic [CNT_W-1:0]              match_count
);

  localparam int LEN_W = len_width(PAT_MAX);

  logic [PAT_MAX-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic [PAT_MAX-1:0] hist_base;
  logic [PAT_MAX:0]   hist_ext;
  logic [PAT_MAX-1:0] hist_next;
  logic [LEN_W-1:0]   fill_base;
  logic [LEN_W-1:0]   fill_next;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_next;
  logic [PAT_MAX-1:0] mask;
  logic               hit;

  // A stream start behaves as if history, fill and count were already zero,
  // so the first bit of the stream is evaluated against a clean slate.
  always_comb begin
    hist_base = start ? '0 : history;
    fill_base = start ? '0 : fill;
    cnt_base  = start ? '0 : match_count;

    hist_ext  = {hist_base, bit_in};
    hist_next = hist_ext[PAT_MAX-1:0];

    if (fill_base >= LEN_W'(PAT_MAX))
      fill_next = LEN_W'(PAT_MAX);
    else
      fill_next = fill_base + LEN_W'(1);

    mask = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++)
      mask[i] = (i < 32'(len));

    hit = (fill_next >= len) && ((hist_next & mask) == (pattern & mask));

    if (hit && (cnt_base != '1))
      cnt_next = cnt_base + CNT_W'(1);
    else
      cnt_next = cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history     <= '0;
      fill        <= '0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= 1'b0;
      if (bit_en) begin
        history     <= hist_next;
        fill        <= (hit && !overlap) ? '0 : fill_next;
        match_pulse <= hit;
        match_count <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/serial_pattern_sched.sv
// serial_pattern_sched
//   Accepts words over valid/ready, serialises them LSB-first into one
//   continuous bit stream, runs a configurable pattern match on it and
//   signals end-of-stream with a one-cycle done pulse.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cfg_we, cfg_pattern, cfg_len,
//   cfg_overlap                     : configuration write (idle only)
//   in_valid, in_data, in_last,
//   in_ready                        : word input handshake
//   bit_out, bit_valid              : serial bit stream
//   match_pulse, match_count        : per-bit match and saturating count
//   busy, done                      : stream in progress / end-of-stream pulse
module serial_pattern_sched
  import serial_pattern_sched_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [PAT_MAX-1:0]            cfg_pattern,
  input  logic [len_width(PAT_MAX)-1:0] cfg_len,
  input  logic                          cfg_overlap,
  input  logic                          in_valid,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          bit_out,
  output logic                          bit_valid,
  output logic                          match_pulse,
  output logic [CNT_W-1:0]              match_count,
  output logic                          busy,
  output logic                          done
);

  localparam int LEN_W = len_width(PAT_MAX);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t              state;
  logic [WORD_W-1:0]   shreg;
  logic [IDX_W-1:0]    bit_idx;
  logic                last;

  logic [PAT_MAX-1:0]  pattern_q;
  logic [LEN_W-1:0]    len_q;
  logic                overlap_q;

  logic                accept;
  logic                cfg_take;
  logic                stream_start;
  logic                shifting;
  logic [LEN_W-1:0]    len_in;
  logic [PAT_MAX-1:0]  pattern_eff;
  logic [LEN_W-1:0]    len_eff;
  logic                overlap_eff;
  logic                core_bit_en;
  logic                core_bit;

  always_comb begin
    accept       = (state == ST_IDLE) && in_valid && in_ready;
    cfg_take     = cfg_we && !busy && (state == ST_IDLE);
    stream_start = accept && !busy;
    len_in       = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    // A write landing with a stream-starting accept must govern that
    // stream's first bit, so bypass the config registers for that cycle.
    pattern_eff  = cfg_take ? cfg_pattern : pattern_q;
    len_eff      = cfg_take ? len_in      : len_q;
    overlap_eff  = cfg_take ? cfg_overlap : overlap_q;

    // The bit that will sit on bit_out next cycle: in_data[0] on accept,
    // otherwise the next shreg bit while the word still has bits left.
    shifting     = (state == ST_SHIFT) && (bit_idx != LAST_IDX);
    core_bit_en  = accept || shifting;
    core_bit     = accept ? in_data[0] : shreg[0];
  end

  // bit_out is registered, so bit 0 is loaded during the accept cycle and
  // shreg holds the remaining bits; bit_idx names the bit currently on
  // bit_out. This keeps one accept cycle plus WORD_W bit cycles per word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      last      <= 1'b0;
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      overlap_q <= 1'b1;
    end else begin
      done <= 1'b0;

      if (cfg_take) begin
        pattern_q <= cfg_pattern;
        len_q     <= len_in;
        overlap_q <= cfg_overlap;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg     <= in_data >> 1;
            last      <= in_last;
            bit_idx   <= '0;
            bit_out   <= in_data[0];
            bit_valid <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bit_idx != LAST_IDX) begin
            bit_out <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IDX_W'(1);
          end else begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end

        ST_DONE: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  pattern_match_core #(
    .PAT_MAX (PAT_MAX),
    .CNT_W   (CNT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .start       (stream_start),
    .bit_en      (core_bit_en),
    .bit_in      (core_bit),
    .pattern     (pattern_eff),
    .len         (len_eff),
    .overlap     (overlap_eff),
    .match_pulse (match_pulse),
    .match_count (match_count)
  );

endmodule

// File: tb/tb_serial_pattern_sched.sv
// tb_serial_pattern_sched
//   Directed stimulus with hand-computed per-bit match masks; expected
//   bit/match/count entries are queued at issue time and a negedge monitor
//   pops and compares them whenever the DUT presents a bit or done.
module tb_serial_pattern_sched;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 4;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 3;
  localparam int CNT_MAX = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic [WORD_W-1:0]  in_data;
  logic               in_last;
  logic               in_ready;
  logic               bit_out;
  logic               bit_valid;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  serial_pattern_sched #(
    .WORD_W  (WORD_W),
    .PAT_MAX (PAT_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic             is_done;
    logic             b;
    logic             m;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  int   exp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bit_valid || done) begin
        if (q.size() == 0) begin
          check("unexpected_output", q.size(), 1);
        end else begin
          mon_e = q.pop_front();
          check("done_slot", done, mon_e.is_done);
          check("bit_valid_slot", bit_valid, !mon_e.is_done);
          if (!mon_e.is_done) begin
            check("bit_out", bit_out, mon_e.b);
            check("match_pulse", match_pulse, mon_e.m);
          end
          check("match_count", match_count, mon_e.cnt);
        end
      end else if (match_pulse) begin
        check("stray_match_pulse", match_pulse, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic [7:0] mask,
                           input logic lst, input bit fresh);
    exp_t e;
    if (fresh) exp_cnt = 0;
    for (int i = 0; i < WORD_W; i++) begin
      if (mask[i] && exp_cnt < CNT_MAX) exp_cnt++;
      e.is_done = 1'b0;
      e.b       = d[i];
      e.m       = mask[i];
      e.cnt     = exp_cnt[CNT_W-1:0];
      q.push_back(e);
    end
    if (lst) begin
      e.is_done = 1'b1;
      e.b       = 1'b0;
      e.m       = 1'b0;
      e.cnt     = exp_cnt[CNT_W-1:0];
      q.push_back(e);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic lst, input bit do_cfg,
                      input logic [3:0] p, input logic [2:0] l, input logic ov);
    wait_ready();
    in_valid    = 1'b1;
    in_data     = d;
    in_last     = lst;
    cfg_we      = do_cfg;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic ov);
    wait_ready();
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(in_ready && !busy) && n < 100) begin
      tick();
      n++;
    end
    if (!(in_ready && !busy)) check("stream_end_timeout", n, 0);
    check("queue_drained", q.size(), 0);
    repeat (3) tick();
    check("count_hold", match_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_match_pulse", match_pulse, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_match_count", match_count, 0);
    rst = 1'b0;
    tick();

    // Reset mid-SHIFT
    cfg(4'b1001, 3'd4, 1'b1);
    send(8'h49, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    tick();
    tick();
    check("pre_reset_bit_valid", bit_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_bit_valid", bit_valid, 0);
    check("midrst_match_count", match_count, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    seen = 0;
    repeat (12) begin
      tick();
      if (done || bit_valid) seen++;
    end
    check("midrst_no_activity", seen, 0);
    q.delete();
    mon_en = 1'b1;

    // 1001 overlapping on 0x49: matches at bits 3 and 6
    cfg(4'b1001, 3'd4, 1'b1);
    push_word(8'h49, 8'b0100_1000, 1'b1, 1'b1);
    send(8'h49, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    wait_done();

    // Non-overlapping: only bit 3
    cfg(4'b1001, 3'd4, 1'b0);
    push_word(8'h49, 8'b0000_1000, 1'b1, 1'b1);
    send(8'h49, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    wait_done();

    // Cross-word 101: match at word 2 bit 1
    cfg(4'b0101, 3'd3, 1'b1);
    push_word(8'h80, 8'b0000_0000, 1'b0, 1'b1);
    send(8'h80, 1'b0, 1'b0, 4'b0, 3'd0, 1'b0);
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      tick();
    end
    check("in_ready_low_cycles", n, 8);
    push_word(8'h02, 8'b0000_0010, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    wait_done();

    // Saturation, config written in the accept cycle itself
    push_word(8'hFF, 8'hFF, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1, 4'b0001, 3'd1, 1'b1);
    wait_done();

    // len=0 behaves as len=1
    cfg(4'b0001, 3'd0, 1'b1);
    push_word(8'h05, 8'b0000_0101, 1'b1, 1'b1);
    send(8'h05, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    wait_done();

    // Config write during SHIFT is ignored; next stream starts fresh
    cfg(4'b1001, 3'd4, 1'b1);
    push_word(8'h49, 8'b0100_1000, 1'b1, 1'b1);
    send(8'h49, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    tick();
    tick();
    cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_len = 3'd1; cfg_overlap = 1'b1;
    tick();
    cfg_we = 1'b0;
    wait_done();
    push_word(8'h09, 8'b0000_1000, 1'b1, 1'b1);
    send(8'h09, 1'b1, 1'b0, 4'b0, 3'd0, 1'b0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_sched.md
Name: serial_pattern_sched

Overview:
- Sequencer and configurator for the serial bit-pattern detector path.
- Accepts parallel words over a valid/ready handshake and serialises them LSB-first into one bit stream that continues across word boundaries.
- Runs a programmable pattern match (pattern value, length, overlap mode) against that stream, emits a per-bit match pulse, and keeps a saturating match count.
- Signals end-of-stream with a one-cycle done pulse; sits between a word-oriented producer and the bit-serial detector/consumer.

Parameters:
- WORD_W, 8, input word width; number of bits serialised per accepted word.
- PAT_MAX, 4, maximum pattern length in bits; also the width of the history register.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_MAX  pattern; bit [len-1] is matched first in time.
- cfg_len  in  $clog2(PAT_MAX+1)  pattern length, 1..PAT_MAX; 0 is treated as 1.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history fill cleared after a match.
- in_valid  in  1  word available.
- in_data  in  WORD_W  word to serialise.
- in_last  in  1  this word ends the stream.
- in_ready  out  1  block accepts a word this cycle.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out is valid.
- match_pulse  out  1  pattern completed by the bit on bit_out.
- match_count  out  CNT_W  matches in the current/last stream, saturating.
- busy  out  1  stream in progress.
- done  out  1  one-cycle pulse after the last bit of a stream.

Behaviour:
- Reset: state IDLE. Outputs in_ready=1, bit_valid=0, bit_out=0, match_pulse=0, done=0, busy=0, match_count=0.
- Reset: history=0, fill=0, pattern=0, len=1, overlap=1.
- Reset wins over all other inputs in the same cycle, including mid-SHIFT; the partial word is discarded.
- All outputs are registered.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and in_last, set bit_idx=0, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle present shreg[0] on bit_out with bit_valid=1, shift right, increment bit_idx.
  - SHIFT exit: after bit WORD_W-1, go to DONE if the captured last=1, else go to IDLE.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Throughput: WORD_W+1 cycles per word (one IDLE accept cycle plus WORD_W shift cycles); no back-to-back accept.
- Stream start: the first word accepted while busy=0 clears match_count, history and fill, and sets busy=1.
- Stream end: match_count holds its value after done until the next stream starts.
- History and fill:
  - Per emitted bit b: history = {history[PAT_MAX-2:0], b}; fill = min(fill+1, PAT_MAX).
  - Match condition: fill (after the update) >= len and history[len-1:0] == pattern[len-1:0].
  - match_pulse is asserted in the same cycle bit_valid presents the completing bit.
  - On a match with overlap=0: fill is set to 0. History is not cleared.
  - History and fill persist across word boundaries within a stream.
- match_count increments on each match_pulse and saturates at 2^CNT_W-1; it never wraps.
- Configuration:
  - cfg_we is accepted only when busy=0 and state is IDLE; otherwise it is silently ignored.
  - A cfg_we in the same cycle as a stream-starting word accept is applied first, so the new stream uses the new configuration.
- in_data, in_last and in_valid are don't-care outside accept cycles.

Decomposition:
- Shared package: state encoding (IDLE, SHIFT, DONE) and the length-width function/constant derived from PAT_MAX.
- One natural sub-module, pattern_match_core: history register, fill counter, compare, overlap clear, saturating counter.
- The parent module holds the handshake FSM, the shift register and the config registers.

Test Plan:
- Reset mid-SHIFT: rst asserted after 3 bits of a word -> next cycle IDLE, in_ready=1, bit_valid=0, match_count=0, no done.
- Pattern 4'b1001, len 4, overlap=1, word 8'h49 with in_last -> bits 1,0,0,1,0,0,1,0; match_pulse on bit indices 3 and 6; done one cycle after bit 7; match_count=2.
- Same stimulus with overlap=0 -> single match at bit 3; match_count=1.
- Cross-word match: pattern 3'b101, len 3; word 8'h80 (no last) then 8'h02 (last) -> exactly one match, at word 2 bit 1; match_count=1; in_ready low for 8 cycles per word.
- Saturation: CNT_W=2, pattern 1'b1, len 1, word 8'hFF with last -> 8 match pulses; match_count reads 1,2,3,3,...; final value 3.
- Config while busy: cfg_we with a new pattern during SHIFT -> ignored; the current stream matches the old pattern. The next stream then starts with a fresh count.
